regfile_wb_sequencer: RTL

- Write-back controller for the Y86-64 15-entry register file, which has a single write port.
- Takes one write-back request per instruction, carrying up to two destinations (dstE/valE and dstM/valM, as in popq), and serialises them onto the register file write port, E first, then M.
- Forwards pending, not-yet-committed values onto the decode read operands.
- Sits between the execute/memory stages and the register file; stalls upstream through a valid/ready handshake.

---
 rtl/regfile_wb_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_sequencer.sv
// Serialises E/M write-back destinations onto the single register file write port,
// forwarding pending values to decode. Optional counters under `WB_STAT_EN`.
module regfile_wb_sequencer #(
   parameter int unsigned      DATA_W = 64,
   parameter int unsigned      RID_W  = 4,
   parameter logic [RID_W-1:0] RNONE  = RID_W'(4'hF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [RID_W-1:0]  wb_dstE,
   input  logic [DATA_W-1:0] wb_valE,
   input  logic [RID_W-1:0]  wb_dstM,
   input  logic [DATA_W-1:0] wb_valM,
   output logic              rf_we,
   output logic [RID_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [RID_W-1:0]  srcA,
   input  logic [RID_W-1:0]  srcB,
   input  logic [DATA_W-1:0] rf_rdataA,
   input  logic [DATA_W-1:0] rf_rdataB,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB,
`ifdef WB_STAT_EN
   output logic [31:0]       wb_commit_cnt,
   output logic [31:0]       wb_stall_cnt,
`endif
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, WR_E, WR_M} state_t;

   state_t              state;
   logic [RID_W-1:0]    dstE_q, dstM_q;
   logic [DATA_W-1:0]   valE_q, valM_q;
   logic                last_wr;
   logic                accept;
   logic                pend_e, pend_m;

   // Last write of the current request; a new request may load behind it.
   always_comb begin
      last_wr  = (state == WR_M) || ((state == WR_E) && (dstM_q == RNONE));
      wb_ready = (state == IDLE) || last_wr;
      accept   = wb_valid && wb_ready;
      pend_e   = (state == WR_E);
      pend_m   = (state == WR_M) || ((state == WR_E) && (dstM_q != RNONE));
   end

   function automatic logic [DATA_W-1:0] fwd(
      input logic [RID_W-1:0]  src,
      input logic [DATA_W-1:0] raw,
      input logic              pe,
      input logic              pm,
      input logic [RID_W-1:0]  de,
      input logic [DATA_W-1:0] ve,
      input logic [RID_W-1:0]  dm,
      input logic [DATA_W-1:0] vm
   );
      logic [DATA_W-1:0] r;
      r = raw;
      if (src == RNONE)
         r = '0;
      else if (pm && (dm == src))
         r = vm;
      else if (pe && (de == src))
         r = ve;
      return r;
   endfunction

   // M is the younger value, so it wins over E on a matching destination.
   always_comb begin
      valA = fwd(srcA, rf_rdataA, pend_e, pend_m, dstE_q, valE_q, dstM_q, valM_q);
      valB = fwd(srcB, rf_rdataB, pend_e, pend_m, dstE_q, valE_q, dstM_q, valM_q);
   end

   // State, latched request and registered write-port outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dstE_q   <= RNONE;
         dstM_q   <= RNONE;
         valE_q   <= '0;
         valM_q   <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         busy     <= 1'b0;
      end else if (accept) begin
         dstE_q <= wb_dstE;
         valE_q <= wb_valE;
         dstM_q <= wb_dstM;
         valM_q <= wb_valM;
         if (wb_dstE != RNONE) begin
            state    <= WR_E;
            rf_we    <= 1'b1;
            rf_waddr <= wb_dstE;
            rf_wdata <= wb_valE;
            busy     <= 1'b1;
         end else if (wb_dstM != RNONE) begin
            state    <= WR_M;
            rf_we    <= 1'b1;
            rf_waddr <= wb_dstM;
            rf_wdata <= wb_valM;
            busy     <= 1'b1;
         end else begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= 1'b0;
         end
      end else if ((state == WR_E) && (dstM_q != RNONE)) begin
         state    <= WR_M;
         rf_we    <= 1'b1;
         rf_waddr <= dstM_q;
         rf_wdata <= valM_q;
         busy     <= 1'b1;
      end else begin
         state    <= IDLE;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         busy     <= 1'b0;
      end
   end

`ifdef WB_STAT_EN
   // Free-running wrap-around statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_commit_cnt <= '0;
         wb_stall_cnt  <= '0;
      end else begin
         if (rf_we)
            wb_commit_cnt <= wb_commit_cnt + 32'd1;
         if (wb_valid && !wb_ready)
            wb_stall_cnt <= wb_stall_cnt + 32'd1;
      end
   end
`endif

endmodule
